sram_fault_model: RTL and testbench

Synthesizable single-port SRAM responder for the csb0/web0/addr0/din0/dout0 port that the MBIST controller drives. It stands in for the OpenRAM macro in RTL simulation and FPGA bring-up. It adds a programmable stuck-at fault table so MBIST pass and fail paths can be exercised. Access counters and an out-of-range flag give the verifier observability.

---
 rtl/sram_model_pkg.sv | 33 +++
 rtl/sram_fault_apply.sv | 40 ++++
 rtl/sram_fault_model.sv | 150 +++++++++++++++
 tb/tb_sram_fault_model.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_model_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_model_pkg
// Description : Shared types and constants for the SRAM fault model.
//               Fault-type encodings, fault-table entry layout and field
//               widths. Entry fields are sized for the largest supported
//               configuration (ADDR_WIDTH <= 16, DATA_WIDTH <= 256).
// Revision    : 1.0 - initial release
// ============================================================================
package sram_model_pkg;

  localparam int FLT_TYPE_W = 2;
  localparam int FLT_ADDR_W = 16;
  localparam int FLT_BIT_W  = 8;

  localparam logic [FLT_TYPE_W-1:0] FLT_OFF  = 2'd0;
  localparam logic [FLT_TYPE_W-1:0] FLT_SA0  = 2'd1;
  localparam logic [FLT_TYPE_W-1:0] FLT_SA1  = 2'd2;
  localparam logic [FLT_TYPE_W-1:0] FLT_RSVD = 2'd3;

  typedef struct packed {
    logic [FLT_TYPE_W-1:0] ftype;
    logic [FLT_ADDR_W-1:0] addr;
    logic [FLT_BIT_W-1:0]  bitpos;
  } flt_entry_t;

  // Reserved encoding behaves like "off".
  function automatic logic flt_is_active(input logic [FLT_TYPE_W-1:0] t);
    return (t == FLT_SA0) || (t == FLT_SA1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_fault_apply.sv
`default_nettype none
// ============================================================================
// Module      : sram_fault_apply
// Description : Combinational stuck-at injection on a read word.
//               Ports: i_tbl  - fault table entries
//                      i_addr - address of the word being read
//                      i_raw  - fault-free stored word
//                      o_word - word with every matching fault applied
// Revision    : 1.0 - initial release
// ============================================================================
module sram_fault_apply
  import sram_model_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_FAULTS = 4
) (
  input  flt_entry_t [NUM_FAULTS-1:0] i_tbl,
  input  logic [ADDR_WIDTH-1:0]       i_addr,
  input  logic [DATA_WIDTH-1:0]       i_raw,
  output logic [DATA_WIDTH-1:0]       o_word
);

  // Entries are visited in ascending index order, so when several entries
  // target the same bit the highest index is the last writer and wins.
  always_comb begin
    o_word = i_raw;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (flt_is_active(i_tbl[i].ftype) && (i_tbl[i].addr == FLT_ADDR_W'(i_addr))) begin
        for (int b = 0; b < DATA_WIDTH; b++) begin
          if (i_tbl[i].bitpos == FLT_BIT_W'(b)) begin
            o_word[b] = (i_tbl[i].ftype == FLT_SA1);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_fault_model.sv
`default_nettype none
// ============================================================================
// Module      : sram_fault_model
// Description : Single-port SRAM responder with a programmable stuck-at
//               fault table, saturating access counters and a sticky
//               out-of-range flag.
//               Ports: clk/rst_n (async active-low reset)
//                      csb0/web0/addr0/din0 -> dout0 (1-cycle read latency)
//                      wmask0 (byte write mask, only with SRAM_WMASK_EN)
//                      flt_valid/flt_ready/flt_idx/flt_addr/flt_bit/flt_type
//                        fault-table write handshake
//                      rd_cnt/wr_cnt/oob_err observability outputs
//               Build option: define SRAM_WMASK_EN to add wmask0.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_fault_model
  import sram_model_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 512,
  parameter int NUM_FAULTS = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          csb0,
  input  logic                          web0,
  input  logic [ADDR_WIDTH-1:0]         addr0,
  input  logic [DATA_WIDTH-1:0]         din0,
`ifdef SRAM_WMASK_EN
  input  logic [DATA_WIDTH/8-1:0]       wmask0,
`endif
  output logic [DATA_WIDTH-1:0]         dout0,
  input  logic                          flt_valid,
  output logic                          flt_ready,
  input  logic [$clog2(NUM_FAULTS)-1:0] flt_idx,
  input  logic [ADDR_WIDTH-1:0]         flt_addr,
  input  logic [$clog2(DATA_WIDTH)-1:0] flt_bit,
  input  logic [1:0]                    flt_type,
  output logic [CNT_WIDTH-1:0]          rd_cnt,
  output logic [CNT_WIDTH-1:0]          wr_cnt,
  output logic                          oob_err
);

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  logic [DATA_WIDTH-1:0]       dout_q,      dout_d;
  logic [CNT_WIDTH-1:0]        rd_cnt_q,    rd_cnt_d;
  logic [CNT_WIDTH-1:0]        wr_cnt_q,    wr_cnt_d;
  logic                        oob_q,       oob_d;
  logic                        flt_ready_q, flt_ready_d;
  flt_entry_t [NUM_FAULTS-1:0] tbl_q,       tbl_d;

  logic                  w_rd;
  logic                  w_wr;
  logic                  w_in_range;
  logic [DATA_WIDTH-1:0] w_raw;
  logic [DATA_WIDTH-1:0] w_faulted;

  assign w_rd = !csb0 && web0;
  assign w_wr = !csb0 && !web0;
  // One extra bit so NUM_WORDS == 2**ADDR_WIDTH compares correctly.
  assign w_in_range = ({1'b0, addr0} < (ADDR_WIDTH+1)'(NUM_WORDS));
  assign w_raw      = w_in_range ? mem[addr0] : '0;

  // Reads see the table as it was before this edge.
  sram_fault_apply #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_FAULTS (NUM_FAULTS)
  ) u_fault_apply (
    .i_tbl  (tbl_q),
    .i_addr (addr0),
    .i_raw  (w_raw),
    .o_word (w_faulted)
  );

  // Storage is never reset and never sees faults.
  always_ff @(posedge clk) begin
    if (w_wr && w_in_range) begin
`ifdef SRAM_WMASK_EN
      for (int k = 0; k < DATA_WIDTH/8; k++) begin
        if (wmask0[k]) begin
          mem[addr0][k*8 +: 8] <= din0[k*8 +: 8];
        end
      end
`else
      mem[addr0] <= din0;
`endif
    end
  end

  always_comb begin
    dout_d      = dout_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    oob_d       = oob_q;
    flt_ready_d = csb0;
    tbl_d       = tbl_q;

    if (w_rd) begin
      dout_d = w_in_range ? w_faulted : '0;
      if (rd_cnt_q != '1) begin
        rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
      end
    end

    if (w_wr && (wr_cnt_q != '1)) begin
      wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
    end

    if (!csb0 && !w_in_range) begin
      oob_d = 1'b1;
    end

    // Ready mirrors last cycle's csb0, so updates land only between accesses.
    if (flt_valid && flt_ready_q) begin
      tbl_d[flt_idx] = '{ftype:  flt_type,
                         addr:   FLT_ADDR_W'(flt_addr),
                         bitpos: FLT_BIT_W'(flt_bit)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q      <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      oob_q       <= 1'b0;
      flt_ready_q <= 1'b1;
      tbl_q       <= '0;
    end else begin
      dout_q      <= dout_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      oob_q       <= oob_d;
      flt_ready_q <= flt_ready_d;
      tbl_q       <= tbl_d;
    end
  end

  assign dout0     = dout_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign oob_err   = oob_q;
  assign flt_ready = flt_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_fault_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_fault_model
// Description : Self-checking bench for sram_fault_model. A behavioural
//               model (word array, fault list resolved highest-index-first)
//               is compared against the DUT on every falling edge, with
//               directed scenarios and randomized traffic. The DUT uses a
//               300-word depth and 10-bit counters so out-of-range accesses
//               and counter saturation are reachable.
//               Build option: SRAM_WMASK_EN enables the byte-mask path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_fault_model;

  localparam int AW   = 9;
  localparam int DW   = 32;
  localparam int NW   = 300;
  localparam int NF   = 4;
  localparam int CW   = 10;
  localparam int NB   = DW/8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          csb0;
  logic          web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [NB-1:0] wmask0;
  logic [DW-1:0] dout0;
  logic          flt_valid;
  logic          flt_ready;
  logic [1:0]    flt_idx;
  logic [AW-1:0] flt_addr;
  logic [4:0]    flt_bit;
  logic [1:0]    flt_type;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] wr_cnt;
  logic          oob_err;

  always #5 clk = ~clk;

  sram_fault_model #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_WORDS  (NW),
    .NUM_FAULTS (NF),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .csb0      (csb0),
    .web0      (web0),
    .addr0     (addr0),
    .din0      (din0),
`ifdef SRAM_WMASK_EN
    .wmask0    (wmask0),
`endif
    .dout0     (dout0),
    .flt_valid (flt_valid),
    .flt_ready (flt_ready),
    .flt_idx   (flt_idx),
    .flt_addr  (flt_addr),
    .flt_bit   (flt_bit),
    .flt_type  (flt_type),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt),
    .oob_err   (oob_err)
  );

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [512];
  logic [DW-1:0] m_dout;
  int            m_rd, m_wr;
  bit            m_oob, m_ready;
  logic [1:0]    m_type  [NF];
  int            m_faddr [NF];
  int            m_fbit  [NF];

  int n_vec  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Each bit is decided by the highest-index active entry that targets it.
  function automatic logic [DW-1:0] m_read(input int a);
    logic [DW-1:0] r;
    r = m_mem[a];
    for (int b = 0; b < DW; b++) begin
      for (int i = NF-1; i >= 0; i--) begin
        if ((m_type[i] == 2'd1 || m_type[i] == 2'd2) && m_faddr[i] == a && m_fbit[i] == b) begin
          r[b] = (m_type[i] == 2'd2);
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] m_mask();
    logic [DW-1:0] mk;
    mk = '1;
`ifdef SRAM_WMASK_EN
    for (int k = 0; k < NB; k++) mk[k*8 +: 8] = {8{wmask0[k]}};
`endif
    return mk;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dout  <= '0;
      m_rd    <= 0;
      m_wr    <= 0;
      m_oob   <= 1'b0;
      m_ready <= 1'b1;
      for (int i = 0; i < NF; i++) m_type[i] <= 2'd0;
    end else begin
      m_ready <= csb0;
      if (!csb0) begin
        if (int'(addr0) >= NW) m_oob <= 1'b1;
        if (web0) begin
          m_dout <= (int'(addr0) < NW) ? m_read(int'(addr0)) : '0;
          m_rd   <= (m_rd < MAXC) ? m_rd + 1 : m_rd;
        end else begin
          if (int'(addr0) < NW)
            m_mem[addr0] <= (m_mem[addr0] & ~m_mask()) | (din0 & m_mask());
          m_wr <= (m_wr < MAXC) ? m_wr + 1 : m_wr;
        end
      end
      if (flt_valid && m_ready) begin
        m_type[flt_idx]  <= flt_type;
        m_faddr[flt_idx] <= int'(flt_addr);
        m_fbit[flt_idx]  <= int'(flt_bit);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("dout0",     dout0,     m_dout);
      chk("rd_cnt",    32'(rd_cnt), 32'(m_rd));
      chk("wr_cnt",    32'(wr_cnt), 32'(m_wr));
      chk("oob_err",   32'(oob_err), 32'(m_oob));
      chk("flt_ready", 32'(flt_ready), 32'(m_ready));
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change on the falling edge and are sampled on the next rising edge.
  task automatic drive(input bit cs, input bit we, input int a, input logic [31:0] d = 0,
                       input bit fv = 0, input int fi = 0, input int fa = 0,
                       input int fb = 0, input int ft = 0, input int m = 15);
    csb0      = cs;
    web0      = we;
    addr0     = AW'(a);
    din0      = d;
    wmask0    = NB'(m);
    flt_valid = fv;
    flt_idx   = 2'(fi);
    flt_addr  = AW'(fa);
    flt_bit   = 5'(fb);
    flt_type  = 2'(ft);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    csb0 = 1'b1; web0 = 1'b1; addr0 = '0; din0 = '0; wmask0 = '1;
    flt_valid = 1'b0; flt_idx = '0; flt_addr = '0; flt_bit = '0; flt_type = '0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    chk("rst_dout",  dout0, 32'h0);
    chk("rst_rd",    32'(rd_cnt), 32'd0);
    chk("rst_oob",   32'(oob_err), 32'd0);
    chk("rst_ready", 32'(flt_ready), 32'd1);

    for (int a = 0; a < NW; a++) drive(0, 0, a, 32'h0);
    for (int a = 0; a < NW; a++) drive(0, 1, a);
    chk("fill_rd",  32'(rd_cnt), 32'd300);
    chk("fill_wr",  32'(wr_cnt), 32'd300);
    chk("fill_oob", 32'(oob_err), 32'd0);

    // Entry 0 = SA1 @ 0x005 bit 3
    drive(1, 1, 0);
    drive(1, 1, 0, 0, 1, 0, 5, 3, 2);
    drive(0, 0, 5, 32'h0);
    drive(0, 1, 5);
    chk("sa1_bit3", dout0, 32'h0000_0008);
    drive(0, 1, 6);
    chk("no_fault_addr6", dout0, 32'h0);

    // Entries 1 (SA1) and 2 (SA0) on the same bit: index 2 wins
    drive(1, 1, 0);
    drive(1, 1, 0, 0, 1, 1, 16, 0, 2);
    drive(1, 1, 0, 0, 1, 2, 16, 0, 1);
    drive(0, 0, 16, 32'hFFFF_FFFF);
    drive(0, 1, 16);
    chk("highest_idx_wins", dout0, 32'hFFFF_FFFE);

    // Stall: request held during an access burst
    drive(0, 1, 6);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 32, 0, 1, 3, 32, 7, 2);
      chk("stall_ready", 32'(flt_ready), 32'd0);
      chk("stall_tbl",   dout0, 32'h0);
    end
    drive(1, 1, 0, 0, 1, 3, 32, 7, 2);
    chk("ready_back", 32'(flt_ready), 32'd1);
    drive(1, 1, 0, 0, 1, 3, 32, 7, 2);
    drive(0, 1, 32);
    chk("accepted_late", dout0, 32'h0000_0080);

    // Out of range
    drive(0, 1, 400);
    chk("oob_rd_dout", dout0, 32'h0);
    chk("oob_set",     32'(oob_err), 32'd1);
    drive(0, 0, 400, 32'hDEAD_BEEF);
    drive(0, 1, 144);
    chk("oob_no_alias", dout0, 32'h0);
    chk("oob_sticky",   32'(oob_err), 32'd1);

`ifdef SRAM_WMASK_EN
    drive(0, 0, 50, 32'h1122_3344, 0, 0, 0, 0, 0, 4'hF);
    drive(0, 0, 50, 32'hAABB_CCDD, 0, 0, 0, 0, 0, 4'h5);
    drive(0, 1, 50);
    chk("wmask_merge", dout0, 32'h11BB_33DD);
`endif

    // Randomized traffic with a mid-run reset
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_dout", dout0, 32'h0);
        chk("mid_rst_rd",   32'(rd_cnt), 32'd0);
        chk("mid_rst_oob",  32'(oob_err), 32'd0);
        rst_n = 1'b1;
      end
      drive($urandom_range(0, 9) < 2, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 15)),
            $urandom,
            $urandom_range(0, 4) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
    end

    // Saturation
    for (int i = 0; i < 1100; i++) drive(0, 1, int'($urandom_range(0, NW-1)));
    chk("rd_sat", 32'(rd_cnt), 32'd1023);
    for (int i = 0; i < 1100; i++) drive(0, 0, int'($urandom_range(0, NW-1)), $urandom);
    chk("wr_sat", 32'(wr_cnt), 32'd1023);

    drive(1, 1, 0);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
